// File: rtl/scaler_matrix_read_ctrl.sv
// Read-side controller for the scaler line-RAM ring: tracks how many source lines are
// buffered, accepts output-row commands and walks one column address per accepted cycle.
`timescale 1ns/1ps
module scaler_matrix_read_ctrl #(
  parameter int KERNEL_MAX       = 4,
  parameter int RAM_NUM          = KERNEL_MAX + 1,
  parameter int RAM_NUM_BITWIDTH = $clog2(RAM_NUM),
  parameter int ADDR_BITWIDTH    = 12,
  parameter int ROW_BITWIDTH     = 12
) (
  input  logic                     core_clk,
  input  logic                     core_rst_n,
  input  logic                     cfg_start,
  input  logic [ADDR_BITWIDTH-1:0] cfg_src_width,
  input  logic [ROW_BITWIDTH-1:0]  cfg_dst_height,
  input  logic                     line_wr_done,
  output logic                     line_wr_ready,
  input  logic                     row_cmd_valid,
  input  logic                     row_cmd_repeat,
  output logic                     row_cmd_ready,
  input  logic                     out_ready,
  output logic                     ram_read_req_en,
  output logic [ADDR_BITWIDTH-1:0] ram_read_req_addr,
  output logic                     matrix_ram_read_done,
  output logic                     matrix_ram_read_repeat,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     credit_err
);

  // One extra bit so a power-of-two ring can still count up to completely full.
  localparam int CW = RAM_NUM_BITWIDTH + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ROW = 2'd1;
  localparam logic [1:0] READ     = 2'd2;
  localparam logic [1:0] ROW_END  = 2'd3;

  logic [1:0]               state;
  logic [ADDR_BITWIDTH-1:0] width;
  logic [ADDR_BITWIDTH-1:0] col_cnt;
  logic [ROW_BITWIDTH-1:0]  height;
  logic [ROW_BITWIDTH-1:0]  row_cnt;
  logic                     rep_lat;
  logic [CW-1:0]            lines_avail;
  logic                     last_col;
  logic                     last_row;
  logic                     line_inc;
  logic                     line_dec;

  assign busy                   = (state != IDLE);
  assign line_wr_ready          = (lines_avail < CW'(RAM_NUM));
  assign row_cmd_ready          = (state == WAIT_ROW) && row_cmd_valid &&
                                  (lines_avail >= CW'(KERNEL_MAX));
  assign last_col               = (col_cnt == width - ADDR_BITWIDTH'(1));
  assign last_row               = (row_cnt == height - ROW_BITWIDTH'(1));
  assign matrix_ram_read_done   = (state == ROW_END);
  assign matrix_ram_read_repeat = matrix_ram_read_done & rep_lat;
  assign frame_done             = matrix_ram_read_done & last_row;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state             <= IDLE;
      width             <= '0;
      height            <= '0;
      col_cnt           <= '0;
      row_cnt           <= '0;
      rep_lat           <= 1'b0;
      ram_read_req_en   <= 1'b0;
      ram_read_req_addr <= '0;
    end else begin
      ram_read_req_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start && (cfg_src_width != '0) && (cfg_dst_height != '0) && !busy) begin
            width   <= cfg_src_width;
            height  <= cfg_dst_height;
            row_cnt <= '0;
            state   <= WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          if (row_cmd_ready) begin
            rep_lat <= row_cmd_repeat;
            col_cnt <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (out_ready) begin
            ram_read_req_en   <= 1'b1;
            ram_read_req_addr <= col_cnt;
            col_cnt           <= col_cnt + ADDR_BITWIDTH'(1);
            if (last_col) state <= ROW_END;
          end
        end
        ROW_END: begin
          row_cnt <= row_cnt + ROW_BITWIDTH'(1);
          state   <= last_row ? IDLE : WAIT_ROW;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A repeated row reuses the window, so only a fresh row retires the oldest line.
  assign line_inc = line_wr_done & line_wr_ready;
  assign line_dec = matrix_ram_read_done & ~rep_lat & (lines_avail != '0);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      lines_avail <= '0;
      credit_err  <= 1'b0;
    end else begin
      if (frame_done)
        lines_avail <= line_wr_done ? CW'(1) : '0;
      else if (line_inc && !line_dec)
        lines_avail <= lines_avail + CW'(1);
      else if (line_dec && !line_inc)
        lines_avail <= lines_avail - CW'(1);

      if (line_wr_done && !line_wr_ready && !frame_done)
        credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scaler_matrix_read_ctrl.sv
// Directed bench for scaler_matrix_read_ctrl: expected strobes and done pulses are
// queued when a command is driven and checked by negedge monitors.
`timescale 1ns/1ps
module tb_scaler_matrix_read_ctrl;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [11:0] cfg_src_width = '0;
  logic [11:0] cfg_dst_height = '0;
  logic        line_wr_done = 1'b0;
  logic        line_wr_ready;
  logic        row_cmd_valid = 1'b0;
  logic        row_cmd_repeat = 1'b0;
  logic        row_cmd_ready;
  logic        out_ready = 1'b1;
  logic        ram_read_req_en;
  logic [11:0] ram_read_req_addr;
  logic        matrix_ram_read_done;
  logic        matrix_ram_read_repeat;
  logic        busy;
  logic        frame_done;
  logic        credit_err;

  int checks = 0;
  int failures = 0;
  logic [11:0] addr_q[$];
  logic [1:0]  done_q[$];   // {repeat, frame_done}

  scaler_matrix_read_ctrl dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .cfg_start(cfg_start), .cfg_src_width(cfg_src_width), .cfg_dst_height(cfg_dst_height),
    .line_wr_done(line_wr_done), .line_wr_ready(line_wr_ready),
    .row_cmd_valid(row_cmd_valid), .row_cmd_repeat(row_cmd_repeat), .row_cmd_ready(row_cmd_ready),
    .out_ready(out_ready), .ram_read_req_en(ram_read_req_en), .ram_read_req_addr(ram_read_req_addr),
    .matrix_ram_read_done(matrix_ram_read_done), .matrix_ram_read_repeat(matrix_ram_read_repeat),
    .busy(busy), .frame_done(frame_done), .credit_err(credit_err)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic start(input int w, input int h);
    cfg_src_width  = 12'(w);
    cfg_dst_height = 12'(h);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic line_pulses(input int n);
    line_wr_done = 1'b1;
    repeat (n) tick();
    line_wr_done = 1'b0;
  endtask

  task automatic send_cmd(input logic rep, input int w, input logic last, output int waited);
    for (int i = 0; i < w; i++) addr_q.push_back(12'(i));
    done_q.push_back({rep, last});
    row_cmd_valid  = 1'b1;
    row_cmd_repeat = rep;
    waited = 0;
    while (waited < 50) begin
      @(negedge core_clk);
      if (row_cmd_ready) break;
      waited++;
    end
    tick();
    row_cmd_valid  = 1'b0;
    row_cmd_repeat = 1'b0;
    if (waited >= 50) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge core_clk);
      if (matrix_ram_read_done) break;
      n++;
    end
    tick();
    if (n >= 100) chk("done_timeout", 0, 1);
  endtask

  // {row_cmd_ready, en, addr, done, repeat, busy, frame_done, credit_err, line_wr_ready}
  function automatic logic [19:0] out_vec();
    return {row_cmd_ready, ram_read_req_en, ram_read_req_addr, matrix_ram_read_done,
            matrix_ram_read_repeat, busy, frame_done, credit_err, line_wr_ready};
  endfunction

  always @(negedge core_clk) begin
    if (core_rst_n) begin
      if (ram_read_req_en) begin
        if (addr_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("strobe_addr", 32'(ram_read_req_addr), 32'(addr_q.pop_front()));
      end
      if (matrix_ram_read_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_repeat_frame", 32'({matrix_ram_read_repeat, frame_done}),
                 32'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #1;
    chk("reset_outputs", 32'(out_vec()), 32'(20'h00001));
    tick();
    tick();
    core_rst_n = 1'b1;
    tick();

    // zero-sized configs must not start a frame
    start(0, 2);
    chk("start_w0_ignored", 32'(busy), 0);
    start(3, 0);
    chk("start_h0_ignored", 32'(busy), 0);

    // two fresh rows of width 3; a busy cfg_start must not disturb the frame
    start(3, 2);
    chk("busy_after_start", 32'(busy), 1);
    line_pulses(4);
    send_cmd(1'b0, 3, 1'b0, w);
    wait_done();
    start(7, 5);
    line_pulses(1);
    send_cmd(1'b0, 3, 1'b1, w);
    wait_done();
    chk("busy_clear_after_frame", 32'(busy), 0);

    // ready withheld until the 4th line (also shows the frame cleared the credits)
    start(3, 3);
    line_pulses(3);
    row_cmd_valid = 1'b1;
    @(negedge core_clk); chk("ready_3lines_a", 32'(row_cmd_ready), 0);
    tick();
    @(negedge core_clk); chk("ready_3lines_b", 32'(row_cmd_ready), 0);
    tick();
    line_wr_done = 1'b1;
    @(negedge core_clk); chk("ready_during_4th", 32'(row_cmd_ready), 0);
    tick();
    line_wr_done = 1'b0;
    send_cmd(1'b1, 3, 1'b0, w);
    chk("ready_after_4th", 32'(w), 0);
    wait_done();
    send_cmd(1'b0, 3, 1'b0, w);
    chk("repeat_keeps_lines", 32'(w), 0);
    wait_done();

    // back-pressure pattern 1,0,0,1,1 across the READ cycles
    line_pulses(1);
    out_ready = 1'b0;
    send_cmd(1'b0, 3, 1'b1, w);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    tick();
    out_ready = 1'b1; tick();
    tick();
    wait_done();
    chk("busy_clear_frame_b", 32'(busy), 0);

    // credit overflow
    line_pulses(4);
    chk("wr_ready_at_4", 32'(line_wr_ready), 1);
    line_pulses(1);
    chk("wr_ready_full", 32'(line_wr_ready), 0);
    chk("credit_err_at_5", 32'(credit_err), 0);
    line_pulses(1);
    chk("credit_err_at_6", 32'(credit_err), 1);
    chk("wr_ready_after_6", 32'(line_wr_ready), 0);

    // reset in the middle of a row
    start(4, 1);
    send_cmd(1'b0, 4, 1'b1, w);
    tick();
    core_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(out_vec()), 32'(20'h00001));
    addr_q.delete();
    done_q.delete();
    tick();
    tick();
    chk("held_reset_outputs", 32'(out_vec()), 32'(20'h00001));
    core_rst_n = 1'b1;
    row_cmd_valid = 1'b1;
    tick();
    tick();
    @(negedge core_clk);
    chk("post_reset_idle_ready", 32'(row_cmd_ready), 0);
    chk("post_reset_idle_busy", 32'(busy), 0);
    tick();
    row_cmd_valid = 1'b0;
    start(4, 1);
    line_pulses(4);
    send_cmd(1'b0, 4, 1'b1, w);
    wait_done();
    chk("busy_clear_after_reset_frame", 32'(busy), 0);

    chk("addr_queue_empty", 32'(addr_q.size()), 0);
    chk("done_queue_empty", 32'(done_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
